decode_bundle_queue: RTL
========================

Name: decode_bundle_queue

Overview:
- Parametrised, multi-lane successor to the single-instruction decoder.
- Decodes a bundle of DECODE_WIDTH RV32 instructions per cycle, adds illegal/operand-use flags, derives per-lane PC, and buffers decoded bundles in a FIFO.
- Sits between fetch and rename with valid/ready handshakes on both sides, and supports flush on branch mispredict.

Parameters:
- DECODE_WIDTH, 2, instructions per bundle (lanes), ≥1.
- PC_W, 32, PC width.
- FIFO_DEPTH, 4, decoded-bundle entries, power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  queue can accept a bundle.
- in_instr  in  32*DECODE_WIDTH  lane i = bits [32i+31:32i].
- in_lane_mask  in  DECODE_WIDTH  lane i holds a real instruction.
- in_pc  in  PC_W  PC of lane 0.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  rename accepts head.
- out_lane_valid  out  DECODE_WIDTH  per-lane valid.
- out_pc  out  PC_W*DECODE_WIDTH  per-lane PC.
- out_opcode  out  7*DECODE_WIDTH  per-lane opcode.
- out_rs1, out_rs2, out_rd  out  5*DECODE_WIDTH each  register indices.
- out_alu_op  out  3*DECODE_WIDTH  ALU operation class.
- out_func3  out  3*DECODE_WIDTH  instr[14:12].
- out_func7  out  7*DECODE_WIDTH  instr[31:25].
- out_fu_alu, out_fu_mem, out_fu_br  out  DECODE_WIDTH each  functional-unit steering.
- out_uses_rs1, out_uses_rs2, out_writes_rd  out  DECODE_WIDTH each  operand usage.
- out_illegal  out  DECODE_WIDTH  unsupported opcode.

Behaviour:
- Per-lane decode is combinational on input; only the decoded fields are stored.
- Decode table (opcode: alu_op, fu_alu/mem/br, rs1/rs2/rd used, func3/func7 kept):
  - 0010011 I-ALU: 011, 1/0/0, y/n/y, f3 and f7.
  - 0110111 LUI: 100, 1/0/0, n/n/y, none.
  - 0110011 R: 010, 1/0/0, y/y/y, f3 and f7.
  - 0000011 Load: 000, 1/1/0, y/n/y, f3.
  - 0100011 Store: 000, 1/1/0, y/y/n, f3.
  - 1100011 Branch: 001, 1/0/1, y/y/n, f3.
  - 1100111 JALR: 110, 1/0/0, y/n/y, f3.
- Unused register fields, and func3/func7 where not kept, decode to 0.
- Any other opcode: all fields 0, illegal=1, lane_valid still 1.
- writes_rd = table value AND rd≠0.
- Masked-off lane: every field 0, lane_valid=0, illegal=0.
- Lane PC = in_pc + 4*i, modulo 2^PC_W (wraps).
- Push: in_valid && in_ready && (in_lane_mask≠0) && !flush.
- Bundle with mask all 0 is accepted (handshake completes) but not stored.
- in_ready = (count < FIFO_DEPTH); it does not depend on out_ready, so there is no push into a full queue even when a pop occurs in the same cycle.
- Pop: out_valid && out_ready.
- Latency: bundle pushed at edge t appears at outputs after edge t; out_valid is high in cycle t+1 if the queue was empty.
- Simultaneous push and pop: count unchanged; head advances and tail writes.
- out_valid = (count≠0).
- When out_valid=0, all out_* data ports are driven 0.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- flush (highest priority): next edge sets head=tail=count=0. Push and pop in the flush cycle are ignored. out_valid=0 the following cycle.
- Reset (asserts asynchronously at any time, including mid-operation): head, tail, count = 0; out_valid=0; in_ready=1 while count=0. Storage contents need no reset; outputs are masked by out_valid.

Test Plan:
- Reset, then push lane0 0x00500093 (addi x1,x0,5), lane1 0x002081B3 (add x3,x1,x2), pc 0x100 → next cycle out_valid=1; lane0 rs1=0, rd=1, alu_op=011, uses_rs2=0; lane1 rs1=1, rs2=2, rd=3, alu_op=010; out_pc = 0x100, 0x104.
- Push 5 bundles with out_ready=0, DEPTH=4 → in_ready=0 after the 4th; 5th not accepted; then out_ready=1 drains the 4 bundles in order; in_ready=1 after the first pop.
- Lane0 0xFFFFFFFF (illegal), lane1 0x00002023 (sw x0,0(x0)), mask=2'b11 → lane0 illegal=1, all fields 0; lane1 fu_mem=1, writes_rd=0, func3=010.
- mask=2'b00 with in_valid=1 → in_ready handshake completes, count unchanged, out_valid stays 0. mask=2'b10 → lane0 lane_valid=0 with all fields 0.
- Queue holds 3 bundles; assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, in_ready=1.
- in_pc=0xFFFFFFFC → lane1 pc=0x00000000. Assert rst_n low mid-stream, asynchronously → out_valid=0 immediately, in_ready=1.

Source files
------------

// File: rtl/decode_bundle_queue.sv
// Multi-lane RV32 decoder feeding a bundle FIFO between fetch and rename.
// Each entry holds fully decoded lanes; outputs are zeroed whenever the queue is empty.
module decode_bundle_queue #(
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [32*DECODE_WIDTH-1:0]   in_instr,
  input  logic [DECODE_WIDTH-1:0]      in_lane_mask,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DECODE_WIDTH-1:0]      out_lane_valid,
  output logic [PC_W*DECODE_WIDTH-1:0] out_pc,
  output logic [7*DECODE_WIDTH-1:0]    out_opcode,
  output logic [5*DECODE_WIDTH-1:0]    out_rs1,
  output logic [5*DECODE_WIDTH-1:0]    out_rs2,
  output logic [5*DECODE_WIDTH-1:0]    out_rd,
  output logic [3*DECODE_WIDTH-1:0]    out_alu_op,
  output logic [3*DECODE_WIDTH-1:0]    out_func3,
  output logic [7*DECODE_WIDTH-1:0]    out_func7,
  output logic [DECODE_WIDTH-1:0]      out_fu_alu,
  output logic [DECODE_WIDTH-1:0]      out_fu_mem,
  output logic [DECODE_WIDTH-1:0]      out_fu_br,
  output logic [DECODE_WIDTH-1:0]      out_uses_rs1,
  output logic [DECODE_WIDTH-1:0]      out_uses_rs2,
  output logic [DECODE_WIDTH-1:0]      out_writes_rd,
  output logic [DECODE_WIDTH-1:0]      out_illegal
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic            lane_valid;
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      alu_op;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic            fu_alu;
    logic            fu_mem;
    logic            fu_br;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic            illegal;
  } lane_t;

  typedef lane_t [DECODE_WIDTH-1:0] bundle_t;

  function automatic lane_t decode_lane(input logic [31:0] ins, input logic en,
                                        input logic [PC_W-1:0] pc);
    lane_t d;
    d = '0;
    if (en) begin
      d.lane_valid = 1'b1;
      d.pc         = pc;
      case (ins[6:0])
        7'b0010011: begin
          d.alu_op = 3'b011; d.fu_alu = 1'b1; d.uses_rs1 = 1'b1; d.writes_rd = 1'b1;
          d.func3 = ins[14:12]; d.func7 = ins[31:25];
        end
        7'b0110111: begin
          d.alu_op = 3'b100; d.fu_alu = 1'b1; d.writes_rd = 1'b1;
        end
        7'b0110011: begin
          d.alu_op = 3'b010; d.fu_alu = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
          d.writes_rd = 1'b1; d.func3 = ins[14:12]; d.func7 = ins[31:25];
        end
        7'b0000011: begin
          d.alu_op = 3'b000; d.fu_alu = 1'b1; d.fu_mem = 1'b1; d.uses_rs1 = 1'b1;
          d.writes_rd = 1'b1; d.func3 = ins[14:12];
        end
        7'b0100011: begin
          d.alu_op = 3'b000; d.fu_alu = 1'b1; d.fu_mem = 1'b1; d.uses_rs1 = 1'b1;
          d.uses_rs2 = 1'b1; d.func3 = ins[14:12];
        end
        7'b1100011: begin
          d.alu_op = 3'b001; d.fu_alu = 1'b1; d.fu_br = 1'b1; d.uses_rs1 = 1'b1;
          d.uses_rs2 = 1'b1; d.func3 = ins[14:12];
        end
        7'b1100111: begin
          d.alu_op = 3'b110; d.fu_alu = 1'b1; d.uses_rs1 = 1'b1; d.writes_rd = 1'b1;
          d.func3 = ins[14:12];
        end
        default: d.illegal = 1'b1;
      endcase
      if (!d.illegal) begin
        d.opcode = ins[6:0];
        d.rs1    = d.uses_rs1  ? ins[19:15] : 5'd0;
        d.rs2    = d.uses_rs2  ? ins[24:20] : 5'd0;
        d.rd     = d.writes_rd ? ins[11:7]  : 5'd0;
        // x0 destinations never count as a register write
        d.writes_rd = d.writes_rd & (|ins[11:7]);
      end
    end
    return d;
  endfunction

  bundle_t              dec_bundle;
  bundle_t              head_bundle;
  bundle_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push, pop;

  always_comb begin
    dec_bundle = '0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      dec_bundle[i] = decode_lane(in_instr[32*i +: 32], in_lane_mask[i],
                                  in_pc + PC_W'(4*i));
    end
  end

  assign in_ready  = (count_q < CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && (|in_lane_mask) && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is unreset; stale contents are hidden by out_valid masking.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= dec_bundle;
  end

  assign head_bundle = out_valid ? mem_q[head_q] : '0;

  always_comb begin
    out_lane_valid = '0;
    out_pc         = '0;
    out_opcode     = '0;
    out_rs1        = '0;
    out_rs2        = '0;
    out_rd         = '0;
    out_alu_op     = '0;
    out_func3      = '0;
    out_func7      = '0;
    out_fu_alu     = '0;
    out_fu_mem     = '0;
    out_fu_br      = '0;
    out_uses_rs1   = '0;
    out_uses_rs2   = '0;
    out_writes_rd  = '0;
    out_illegal    = '0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      out_lane_valid[i]       = head_bundle[i].lane_valid;
      out_pc[PC_W*i +: PC_W]  = head_bundle[i].pc;
      out_opcode[7*i +: 7]    = head_bundle[i].opcode;
      out_rs1[5*i +: 5]       = head_bundle[i].rs1;
      out_rs2[5*i +: 5]       = head_bundle[i].rs2;
      out_rd[5*i +: 5]        = head_bundle[i].rd;
      out_alu_op[3*i +: 3]    = head_bundle[i].alu_op;
      out_func3[3*i +: 3]     = head_bundle[i].func3;
      out_func7[7*i +: 7]     = head_bundle[i].func7;
      out_fu_alu[i]           = head_bundle[i].fu_alu;
      out_fu_mem[i]           = head_bundle[i].fu_mem;
      out_fu_br[i]            = head_bundle[i].fu_br;
      out_uses_rs1[i]         = head_bundle[i].uses_rs1;
      out_uses_rs2[i]         = head_bundle[i].uses_rs2;
      out_writes_rd[i]        = head_bundle[i].writes_rd;
      out_illegal[i]          = head_bundle[i].illegal;
    end
  end

endmodule
